// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks the register file read port and streams {index, value} beats
// Optional macro REGDUMP_SKIP_ZERO_EN: entries that read as zero are skipped and produce no beat.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_idx_o,
   output logic [DATA_W-1:0] out_data_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         out_idx_q  <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         out_idx_q  <= out_idx_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      out_idx_d  = out_idx_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_ADDR;
               idx_d   = '0;
            end
         end
         S_ADDR: begin
`ifdef REGDUMP_SKIP_ZERO_EN
            if (rd_data_i == '0) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end else begin
               out_idx_d  = idx_q;
               out_data_d = rd_data_i;
               state_d    = S_HOLD;
            end
`else
            out_idx_d  = idx_q;
            out_data_d = rd_data_i;
            state_d    = S_HOLD;
`endif
         end
         S_HOLD: begin
            // The captured beat stays frozen until the consumer takes it.
            if (out_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_ADDR;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // idx_q only moves on entry to ADDR, so it doubles as the held read address.
   assign rd_addr_o   = idx_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign out_valid_o = (state_q == S_HOLD);
   assign out_idx_o   = out_idx_q;
   assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed table-driven bench for regfile_dump_reader
// Optional macro REGDUMP_SKIP_ZERO_EN selects the zero-skip scenarios.
module tb_regfile_dump_reader;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic [31:0] out_data;

   logic [31:0] regs [N];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int          stall;
      logic [4:0]  idx;
      logic [31:0] data;
      int          cyc;
   } beat_t;

   beat_t tab [N];
   int    n_exp;
   int    exp_done;

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr];

   regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .rd_addr_o   (rd_addr),
      .rd_data_i   (rd_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_idx_o   (out_idx),
      .out_data_o  (out_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic preload_mul3();
      for (int i = 0; i < N; i++) regs[i] = 32'(i * 3);
   endtask

   task automatic fill_full(input int stall_beat, input int stall_len);
      for (int i = 0; i < N; i++) begin
         tab[i].stall = (i == stall_beat) ? stall_len : 0;
         tab[i].idx   = 5'(i);
         tab[i].data  = 32'(i * 3);
         tab[i].cyc   = 2 + 2 * i + ((stall_beat >= 0 && i > stall_beat) ? stall_len : 0)
                        + ((i == stall_beat) ? stall_len : 0);
      end
      n_exp    = N;
      exp_done = 2 * N + 1 + stall_len;
   endtask

   // Starts a dump at edge 0 and checks each accepted beat against tab[].
   task automatic run_dump(input int restart_beat);
      int beats    = 0;
      int dones    = 0;
      int done_cyc = -1;
      int stalled  = 0;
      bit restarted = 0;
      cyc       = 0;
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      while (cyc < 400) begin
         start = 1'b0;
         if (done) begin
            dones++;
            if (dones == 1) begin
               done_cyc = cyc;
               chk("busy_in_done", busy, 1);
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         if (out_valid) begin
            if (beats >= n_exp) begin
               out_ready = 1'b1;
               beats++;
            end else if (stalled < tab[beats].stall) begin
               out_ready = 1'b0;
               chk("stall_idx", out_idx, tab[beats].idx);
               chk("stall_data", out_data, tab[beats].data);
               if (stalled == 2) regs[tab[beats].idx] = 32'd99;
               stalled++;
            end else begin
               out_ready = 1'b1;
               chk("beat_idx", out_idx, tab[beats].idx);
               chk("beat_data", out_data, tab[beats].data);
               chk("beat_cycle", 64'(cyc), 64'(tab[beats].cyc));
               if (beats == restart_beat && !restarted) begin
                  start     = 1'b1;
                  restarted = 1'b1;
               end
               beats++;
               stalled = 0;
            end
         end else begin
            out_ready = 1'b1;
         end
         step();
      end
      chk("beat_count", 64'(beats), 64'(n_exp));
      chk("done_count", 64'(dones), 1);
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) regs[i] = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_rd_addr", rd_addr, 0);
      end
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_data", out_data, 0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk("idle_no_start", busy, 0);

`ifdef REGDUMP_SKIP_ZERO_EN
      begin
         int si [6] = '{9, 10, 12, 16, 17, 18};
         int sd [6] = '{9, 16, 16, 4, 1, 1};
         int sc [6] = '{11, 13, 16, 21, 23, 25};
         for (int i = 0; i < N; i++) regs[i] = '0;
         for (int i = 0; i < 6; i++) begin
            regs[si[i]]  = 32'(sd[i]);
            tab[i].stall = 0;
            tab[i].idx   = 5'(si[i]);
            tab[i].data  = 32'(sd[i]);
            tab[i].cyc   = sc[i];
         end
         n_exp    = 6;
         exp_done = 39;
         run_dump(-1);
         for (int i = 0; i < N; i++) regs[i] = '0;
         n_exp    = 0;
         exp_done = N + 1;
         run_dump(-1);
      end
`else
      preload_mul3();
      fill_full(-1, 0);
      run_dump(-1);

      preload_mul3();
      fill_full(4, 5);
      run_dump(-1);

      preload_mul3();
      fill_full(-1, 0);
      run_dump(10);

      preload_mul3();
      cyc       = 0;
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int t = 0; t < 100 && !(out_valid && out_idx == 5'd7); t++) step();
      chk("mid_reach_valid", out_valid, 1);
      chk("mid_reach_idx", out_idx, 7);
      rst = 1'b1;
      step();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_idx", out_idx, 0);
      chk("mid_rst_data", out_data, 0);
      rst = 1'b0;
      step();
      chk("mid_rst_idle", busy, 0);
      fill_full(-1, 0);
      run_dump(-1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader that walks the 32x32 general-purpose register file through one of its combinational read ports.
- Streams each {index, value} pair out on a valid/ready interface.
- Replaces per-cycle simulation print loops with a synthesizable, host-visible dump path.
- Sits beside the register file and drives its read-address input when the debug mux selects it.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; ignored unless idle.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rd_addr  output  ADDR_W  read address to the register file read port.
- rd_data  input  DATA_W  combinational read data returned for rd_addr.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer ready.
- out_idx  output  ADDR_W  register index of current beat.
- out_data  output  DATA_W  register value of current beat.

Behaviour:
- Reset values (any cycle rst=1): state IDLE; index counter 0; rd_addr 0; busy 0; done 0; out_valid 0; out_idx 0; out_data 0. Reset wins over every other input, including mid-dump; no partial beat survives it.
- States: IDLE, ADDR, HOLD, DONE.
- IDLE:
  - start=1 at a posedge -> ADDR with index 0.
  - start=0 -> stay.
- ADDR:
  - rd_addr = index.
  - At the posedge, capture rd_data into out_data and index into out_idx, then go to HOLD.
  - Register file writes land on negedge, so the value captured is the one present after any same-cycle write.
- HOLD:
  - out_valid=1. out_idx and out_data are frozen while waiting, even if the register file changes.
  - out_valid=1 and out_ready=1 at a posedge = beat transferred.
  - After a transfer: if index = NUM_REGS-1 go to DONE; otherwise index+1 and go to ADDR.
  - No transfer -> stay in HOLD.
- DONE: done=1 for exactly one cycle, then IDLE; busy drops in the same transition.
- Timing:
  - start accepted at edge 0 -> ADDR in cycle 1 -> out_valid from cycle 2.
  - Minimum 2 cycles per beat. With out_ready tied high, beat k is valid in cycle 2+2k and done is high in cycle 2*NUM_REGS+1.
- start while busy (ADDR/HOLD/DONE): ignored; no restart, no queueing.
- Index counter saturates: it never wraps past NUM_REGS-1 during a dump and returns to 0 on the next accepted start.
- out_ready while out_valid=0: no effect.
- Register 0 is dumped like any other index; its value is whatever the register file returns.
- rd_addr holds its last value while in IDLE, HOLD and DONE.

Optional Feature:
- Macro: REGDUMP_SKIP_ZERO_EN
- Defined:
  - In ADDR, if rd_data = 0 the entry is skipped: no HOLD, no beat.
  - If not last: index+1, stay in ADDR.
  - If last: go to DONE.
  - A skipped entry costs 1 cycle.
  - A register file that is all zero produces zero beats; done pulses NUM_REGS+1 cycles after start is accepted.
- Undefined: every index produces a beat, including zero values.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1 -> busy, done and out_valid stay 0, rd_addr=0.
- Full dump:
  - Preload reg[i]=i*3, out_ready tied 1, pulse start -> 32 beats with out_idx 0..31 and out_data 0,3,...,93.
  - Beat k is valid in cycle 2+2k; done pulses in cycle 65 only.
- Backpressure:
  - Drop out_ready for 5 cycles on beat 4 (reg[4]=12) -> out_valid stays high and out_idx=4, out_data=12 stay stable.
  - Change reg[4] to 99 during the stall -> out_data stays 12.
  - Next beat is idx 5.
- Start while busy: pulse start again during beat 10 -> no restart, exactly 32 beats total, one done pulse.
- Reset mid-dump: assert rst during HOLD of beat 7 -> next cycle out_valid=0, busy=0. A fresh start dumps from idx 0.
- With REGDUMP_SKIP_ZERO_EN: reg[9]=9, reg[10]=16, reg[12]=16, reg[16]=4, reg[17]=1, reg[18]=1, all others 0 -> exactly 6 beats, idx 9,10,12,16,17,18, then one done pulse.
